// File: rtl/button_event_decoder.sv
// Purpose: turns a debounced button level into single-cycle press/release/short/long/repeat events.
// Latency: every output is registered on the same edge that samples its cause (1 cycle from clean).
// Backpressure: none; the event pulses are fire-and-forget and there is no ready input.
// Optional feature: define BTN_AUTOREPEAT_EN to enable repeat_pulse/rep_count while a press is held long.
module button_event_decoder #(
    parameter int LONG_TICKS   = 10000,
    parameter int REPEAT_TICKS = 2000,
    parameter int CNT_BITS     = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clean,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] rep_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_LONG  = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

    // The hold counter never needs to go past the larger of the two periods.
    localparam int CNT_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam logic [CNT_BITS-1:0] CNT_TOP = CNT_BITS'(CNT_MAX - 1);
    // Press is entered with cnt = 0, so reaching LONG_TICKS-1 means the button has
    // been held LONG_TICKS cycles since press_pulse.
    localparam logic [CNT_BITS-1:0] LONG_TC = CNT_BITS'(LONG_TICKS - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_BITS-1:0] REP_TC  = CNT_BITS'(REPEAT_TICKS - 1);
`endif

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d, cnt_inc;
    logic                prev_q;
    logic                rise, fall;
    logic                press_q, release_q, short_q, long_q, repeat_q, held_q;
    logic                press_d, release_d, short_d, long_d, repeat_d, held_d;
    logic [7:0]          rep_count_q, rep_count_d;

    assign rise    = clean & ~prev_q;
    assign fall    = ~clean & prev_q;
    assign cnt_inc = (cnt_q == CNT_TOP) ? '0 : cnt_q + 1'b1;

    // Next-state, counter and event decode; fall always wins over a terminal count.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        short_d     = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rep_count_d = rep_count_q;
`else
        rep_count_d = 8'd0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d     = S_PRESS;
                    press_d     = 1'b1;
                    cnt_d       = '0;
                    rep_count_d = 8'd0;
                end
            end
            S_PRESS: begin
                if (fall) begin
                    state_d   = S_IDLE;
                    short_d   = 1'b1;
                    release_d = 1'b1;
                end else if (cnt_q == LONG_TC) begin
                    state_d = S_LONG;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_LONG: begin
                if (fall) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    if (cnt_q == REP_TC) begin
                        repeat_d    = 1'b1;
                        cnt_d       = '0;
                        rep_count_d = (rep_count_q == 8'hFF) ? 8'hFF : rep_count_q + 8'd1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`else
                    // Without auto-repeat the long state just parks until release.
                    cnt_d = cnt_q;
`endif
                end
            end
            S_LOCK: begin
                // Button was already down at reset: wait for it to go up silently.
                if (fall) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        held_d = (state_d == S_PRESS) || (state_d == S_LONG);
    end

    // State, counter and registered outputs; reset drops in-flight events.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= clean ? S_LOCK : S_IDLE;
            cnt_q       <= '0;
            prev_q      <= clean;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
            held_q      <= 1'b0;
            rep_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_q      <= clean;
            press_q     <= press_d;
            release_q   <= release_d;
            short_q     <= short_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
            held_q      <= held_d;
            rep_count_q <= rep_count_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;
    assign rep_count     = rep_count_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Testbench for button_event_decoder: directed scenarios plus random hold lengths,
// each edge checked against a timestamp-based reference model.
module tb_button_event_decoder;

    localparam int LT = 8;
    localparam int RT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       clean;
    logic       press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;
    logic [7:0] rep_count;

    always #5 clk = ~clk;

    button_event_decoder #(
        .LONG_TICKS  (LT),
        .REPEAT_TICKS(RT),
        .CNT_BITS    (14)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clean        (clean),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .rep_count    (rep_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int edge_no = 0;

    // Reference model: a press is a timestamp; everything else is derived from its age.
    bit m_prev = 1'b0;
    bit m_down = 1'b0;
    bit m_lock = 1'b0;
    int m_press_edge = 0;
    int m_rep = 0;
    bit e_press, e_release, e_short, e_long, e_repeat, e_held;
    int last_press_dut = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", tag, got, exp, edge_no);
        end
    endtask

    task automatic model_edge(input bit c, input bit r);
        int age;
        e_press = 0; e_release = 0; e_short = 0; e_long = 0; e_repeat = 0;
        if (r) begin
            m_down = 0;
            m_lock = c;
            m_rep  = 0;
        end else begin
            if (m_down) begin
                age = edge_no - m_press_edge;
                if (!c && m_prev) begin
                    e_release = 1;
                    e_short   = (age <= LT);
                    m_down    = 0;
                end else begin
                    e_long = (age == LT);
`ifdef BTN_AUTOREPEAT_EN
                    if (age > LT) begin
                        e_repeat = ((age - LT) % RT) == 0;
                        m_rep    = ((age - LT) / RT > 255) ? 255 : (age - LT) / RT;
                    end
`endif
                end
            end else if (m_lock) begin
                if (!c && m_prev) m_lock = 0;
            end else if (c && !m_prev) begin
                m_down       = 1;
                m_press_edge = edge_no;
                m_rep        = 0;
                e_press      = 1;
            end
        end
        e_held = m_down;
        m_prev = c;
    endtask

    task automatic step(input bit c, input bit r);
        clean = c;
        reset = r;
        @(posedge clk);
        edge_no++;
        model_edge(c, r);
        #1;
        check_val("press",   press_pulse,   e_press);
        check_val("release", release_pulse, e_release);
        check_val("short",   short_pulse,   e_short);
        check_val("long",    long_pulse,    e_long);
        check_val("repeat",  repeat_pulse,  e_repeat);
        check_val("held",    held,          e_held);
        check_val("rep_count", rep_count,   m_rep);
        if (press_pulse === 1'b1) last_press_dut = edge_no;
        if (long_pulse === 1'b1) check_val("long_latency", edge_no - last_press_dut, LT);
    endtask

    task automatic run(input bit c, input int n);
        for (int i = 0; i < n; i++) step(c, 1'b0);
    endtask

    initial begin
        bit lvl;
        int len;
        clean = 1'b0;
        reset = 1'b1;

        // Reset with button up.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        run(1'b0, 5);

        // Short click: 4 cycles high.
        run(1'b1, 4);
        run(1'b0, 5);

        // Long + repeat: high for 20 sampled edges starting at the press edge.
        run(1'b1, 20);
`ifdef BTN_AUTOREPEAT_EN
        check_val("rep_after_long", rep_count, 3);
`else
        check_val("rep_after_long", rep_count, 0);
`endif
        run(1'b0, 3);

        // Tie: fall sampled exactly on the long terminal edge -> short only.
        run(1'b1, LT);
        run(1'b0, 3);
        // One cycle shorter and one cycle longer around the boundary.
        run(1'b1, LT - 1);
        run(1'b0, 2);
        run(1'b1, LT + 1);
        run(1'b0, 2);

        // Reset with button down -> locked until a release, then a fresh press.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        run(1'b1, 7);
        run(1'b0, 8);
        run(1'b1, 3);
        run(1'b0, 2);

        // Reset mid-LONG: outputs clear, lock, no release on the later fall.
        run(1'b1, 12);
        step(1'b1, 1'b1);
        check_val("held_after_reset", held, 0);
        run(1'b1, 4);
        run(1'b0, 3);

        // Very long hold: rep_count saturates at 255.
        run(1'b1, LT + RT * 260);
`ifdef BTN_AUTOREPEAT_EN
        check_val("rep_saturate", rep_count, 255);
`else
        check_val("rep_saturate", rep_count, 0);
`endif
        run(1'b0, 2);
        run(1'b1, 2);
        check_val("rep_cleared", rep_count, 0);
        run(1'b0, 2);

        // Random hold/release lengths around the interesting boundaries.
        lvl = 1'b0;
        for (int s = 0; s < 200; s++) begin
            lvl = ~lvl;
            len = $urandom_range(1, LT + 4 * RT + 3);
            if ($urandom_range(0, 19) == 0) step(lvl, 1'b1);
            run(lvl, len);
        end
        run(1'b0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
